// File: rtl/systolic_mac_array.sv
// systolic_mac_array: output-stationary ROWSxCOLS saturating MAC array with built-in
// input skew, drain sequencing, done pulse and registered result read-back.
module systolic_mac_array #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 16,
  parameter int KW   = 8,
  parameter int RW   = ROWS > 1 ? $clog2(ROWS) : 1,
  parameter int CW   = COLS > 1 ? $clog2(COLS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 a_vld,
  output logic                 a_rdy,
  input  logic [ROWS*DW-1:0]   a_data,
  input  logic [COLS*DW-1:0]   b_data,
  output logic                 busy,
  output logic                 done,
  input  logic                 rd_en,
  input  logic [RW-1:0]        rd_row,
  input  logic [CW-1:0]        rd_col,
  output logic [DW-1:0]        rd_data,
  output logic                 rd_sat
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  localparam int NW = $clog2(ROWS + COLS);
  localparam logic signed [2*DW:0] MAXV = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW:0] MINV = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};
  state_t state_q, state_d;
  logic [KW-1:0] klen_q, klen_d, cnt_q, cnt_d;
  logic [NW-1:0] drn_q, drn_d;
  logic done_q, done_d, clr, adv;
  logic [DW-1:0] rd_data_q;
  logic rd_sat_q;
  logic signed [DW-1:0] a_w [ROWS][COLS];
  logic signed [DW-1:0] b_w [ROWS][COLS];
  logic signed [DW-1:0] acc_w [ROWS][COLS];
  logic sat_w [ROWS][COLS];
  assign clr   = start && (state_q == IDLE || state_q == DONE);
  assign adv   = (state_q == LOAD && a_vld) || state_q == DRAIN;
  assign a_rdy = state_q == LOAD;
  assign busy  = state_q == LOAD || state_q == DRAIN;
  assign done  = done_q;
  assign rd_data = rd_data_q;
  assign rd_sat  = rd_sat_q;
  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        klen_d  = k_len;
        cnt_d   = '0;
        drn_d   = '0;
        state_d = k_len == '0 ? DONE : LOAD;
        done_d  = k_len == '0;
      end
      LOAD: if (a_vld) begin
        cnt_d   = cnt_q + KW'(1);
        state_d = cnt_q == klen_q - KW'(1) ? DRAIN : LOAD;
      end
      DRAIN: begin
        drn_d   = drn_q + NW'(1);
        state_d = drn_q == NW'(ROWS + COLS - 2) ? DONE : DRAIN;
        done_d  = drn_q == NW'(ROWS + COLS - 2);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      klen_q  <= '0;
      cnt_q   <= '0;
      drn_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      done_q  <= done_d;
    end
  end
  // Row r of A enters through r skew stages so PE(r,c) sees slice k at advance k+r+c.
  for (genvar r = 0; r < ROWS; r++) begin : g_a
    logic signed [DW-1:0] a_in;
    assign a_in = state_q == DRAIN ? '0 : a_data[r*DW +: DW];
    if (r == 0) begin : g_nosk
      assign a_w[r][0] = a_in;
    end else begin : g_sk
      logic signed [DW-1:0] sk_q [r];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) for (int i = 0; i < r; i++) sk_q[i] <= '0;
        else if (clr) for (int i = 0; i < r; i++) sk_q[i] <= '0;
        else if (adv) begin
          sk_q[0] <= a_in;
          for (int i = 1; i < r; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign a_w[r][0] = sk_q[r-1];
    end
  end
  for (genvar c = 0; c < COLS; c++) begin : g_b
    logic signed [DW-1:0] b_in;
    assign b_in = state_q == DRAIN ? '0 : b_data[c*DW +: DW];
    if (c == 0) begin : g_nosk
      assign b_w[0][c] = b_in;
    end else begin : g_sk
      logic signed [DW-1:0] sk_q [c];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) for (int i = 0; i < c; i++) sk_q[i] <= '0;
        else if (clr) for (int i = 0; i < c; i++) sk_q[i] <= '0;
        else if (adv) begin
          sk_q[0] <= b_in;
          for (int i = 1; i < c; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign b_w[0][c] = sk_q[c-1];
    end
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic signed [DW-1:0] acc_q, acc_d;
      logic sat_q, sat_d, hi, lo;
      logic signed [2*DW-1:0] p;
      logic signed [2*DW:0] s;
      always_comb begin
        p     = (2*DW)'(a_w[r][c]) * (2*DW)'(b_w[r][c]);
        s     = (2*DW+1)'(acc_q) + (2*DW+1)'(p);
        hi    = s > MAXV;
        lo    = s < MINV;
        acc_d = hi ? MAXV[DW-1:0] : lo ? MINV[DW-1:0] : s[DW-1:0];
        sat_d = sat_q | hi | lo;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q <= '0;
          sat_q <= 1'b0;
        end else if (clr) begin
          acc_q <= '0;
          sat_q <= 1'b0;
        end else if (adv) begin
          acc_q <= acc_d;
          sat_q <= sat_d;
        end
      end
      assign acc_w[r][c] = acc_q;
      assign sat_w[r][c] = sat_q;
      if (c < COLS - 1) begin : g_ah
        logic signed [DW-1:0] a_q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) a_q <= '0;
          else if (clr) a_q <= '0;
          else if (adv) a_q <= a_w[r][c];
        end
        assign a_w[r][c+1] = a_q;
      end
      if (r < ROWS - 1) begin : g_bh
        logic signed [DW-1:0] b_q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) b_q <= '0;
          else if (clr) b_q <= '0;
          else if (adv) b_q <= b_w[r][c];
        end
        assign b_w[r+1][c] = b_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_sat_q  <= 1'b0;
    end else if (rd_en) begin
      rd_data_q <= 32'(rd_row) < ROWS && 32'(rd_col) < COLS ? acc_w[rd_row][rd_col] : '0;
      rd_sat_q  <= 32'(rd_row) < ROWS && 32'(rd_col) < COLS ? sat_w[rd_row][rd_col] : 1'b0;
    end
  end
endmodule
